// File: rtl/fifo32_sync.sv
// Synchronous single-clock 32-bit FIFO between the APB write path and the read controller.
// Occupancy-based full/empty, registered read data, sticky overflow/underflow flags.
module fifo32_sync #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write,
  input  logic [31:0]   data_write,
  input  logic          read,
  output logic [31:0]   data_read,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          rd_acc;
  logic          wr_acc;

  always_comb begin
    rd_acc = read && !empty;
    // A pop on the same edge frees a slot, so a full FIFO still takes the write.
    wr_acc = write && (!full || rd_acc);
  end

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst)
      mem[wr_ptr] <= data_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      data_read <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + AW'(1);
        data_read <= mem[rd_ptr];
      end
      if (wr_acc && !rd_acc)
        count_q <= count_q + (AW+1)'(1);
      else if (rd_acc && !wr_acc)
        count_q <= count_q - (AW+1)'(1);

      // New error events take priority over clr_err.
      if (write && !wr_acc)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (read && !rd_acc)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo32_sync.sv
// Directed self-checking bench for fifo32_sync (DEPTH=8, AF_LEVEL=6).
// Expected values are hand-computed or taken from a small queue model in the wrap phase.
module tb_fifo32_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [31:0] data_write;
  logic        read;
  logic [31:0] data_read;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  int errors = 0;
  int checks = 0;

  fifo32_sync #(.DEPTH(8), .AW(3), .AF_LEVEL(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .data_write  (data_write),
    .read        (read),
    .data_read   (data_read),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_dr;
    logic [19:0] wpat;
    logic [19:0] rpat;
    logic        rd_ok;
    logic        wr_ok;

    rst = 1'b1; write = 1'b1; read = 1'b1; clr_err = 1'b1;
    data_write = 32'hFFFF_FFFF;

    // Reset for two cycles with write/read active.
    step();
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dread", data_read, 32'h0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    rst = 1'b0; write = 1'b0; read = 1'b0; clr_err = 1'b0;
    step();
    chk("post_rst_count", 32'(count), 32'd0);

    // Fill.
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; data_write = 32'hA000_0000 + 32'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (i + 1 == 8) ? 32'd1 : 32'd0);
    end

    // Overflow on write while full.
    data_write = 32'hDEAD_BEEF;
    step();
    write = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);

    // Drain with back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      read = 1'b1;
      step();
      chk("drain_data", data_read, 32'hA000_0000 + 32'(i));
      chk("drain_count", 32'(count), 32'(7 - i));
    end
    read = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    step();
    chk("hold_data", data_read, 32'hA000_0007);

    // Underflow on read while empty.
    read = 1'b1;
    step();
    read = 1'b0;
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_data", data_read, 32'hA000_0007);
    chk("unf_count", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    step();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_unf", 32'(underflow), 32'd0);

    // New underflow in the same cycle as clr_err: set wins.
    read = 1'b1;
    step();
    read = 1'b0;
    chk("setwin_unf", 32'(underflow), 32'd1);
    chk("setwin_ovf", 32'(overflow), 32'd0);
    step();
    clr_err = 1'b0;
    chk("clr2_unf", 32'(underflow), 32'd0);

    // Simultaneous read/write while full.
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; data_write = 32'hB000_0000 + 32'(i);
      step();
    end
    chk("simf_pre_full", 32'(full), 32'd1);
    read = 1'b1; data_write = 32'h1234_5678;
    step();
    write = 1'b0;
    chk("simf_count", 32'(count), 32'd8);
    chk("simf_data", data_read, 32'hB000_0000);
    chk("simf_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 9; i++) begin
      step();
      chk("simf_drain", data_read, (i == 8) ? 32'h1234_5678 : 32'hB000_0000 + 32'(i));
    end
    read = 1'b0;
    chk("simf_empty", 32'(count), 32'd0);

    // Simultaneous read/write while empty: no fall-through.
    write = 1'b1; read = 1'b1; data_write = 32'h5555_AAAA;
    step();
    write = 1'b0; read = 1'b0;
    chk("sime_unf", 32'(underflow), 32'd1);
    chk("sime_count", 32'(count), 32'd1);
    chk("sime_data", data_read, 32'h1234_5678);
    read = 1'b1; clr_err = 1'b1;
    step();
    read = 1'b0; clr_err = 1'b0;
    chk("sime_pop", data_read, 32'h5555_AAAA);
    chk("sime_clr", 32'(underflow), 32'd0);

    // Mixed traffic crossing the pointer wrap, against a queue model.
    exp_dr = 32'h5555_AAAA;
    wpat = 20'hEFB7D;
    rpat = 20'h5A96B;
    for (int i = 0; i < 20; i++) begin
      write = wpat[i]; read = rpat[i]; data_write = 32'hC000_0000 + 32'(i);
      rd_ok = read && (q.size() > 0);
      wr_ok = write && (q.size() < 8 || rd_ok);
      if (rd_ok) exp_dr = q.pop_front();
      if (wr_ok) q.push_back(data_write);
      step();
      chk("wrap_data", data_read, exp_dr);
      chk("wrap_count", 32'(count), 32'(q.size()));
    end
    write = 1'b0; read = 1'b0;

    // Mid-operation reset with three words stored, write/read also active.
    clr_err = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; data_write = 32'hD000_0000 + 32'(i);
      step();
    end
    chk("mid_pre_count", 32'(count), 32'd3);
    rst = 1'b1; read = 1'b1; data_write = 32'hEEEE_EEEE;
    step();
    rst = 1'b0; read = 1'b0; write = 1'b0;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_dread", data_read, 32'h0);
    write = 1'b1; data_write = 32'hE000_0001;
    step();
    write = 1'b0; read = 1'b1;
    step();
    read = 1'b0;
    chk("mid_new_data", data_read, 32'hE000_0001);
    chk("mid_new_count", 32'(count), 32'd0);
    read = 1'b1;
    step();
    read = 1'b0;
    chk("mid_no_stale", 32'(underflow), 32'd1);
    chk("mid_hold", data_read, 32'hE000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo32_sync.md
Name: fifo32_sync

Overview:
- Synchronous single-clock 32-bit FIFO that buffers words between the APB write path and the FIFO read controller.
- The write side accepts one word per cycle from the register/APB write logic.
- The read side is popped by the downstream read controller through `read`, which sees `empty` and `data_read`.
- Provides occupancy, `almost_full`, and sticky overflow/underflow error flags.

Parameters:
- DEPTH, 8, number of 32-bit entries; power of two, minimum 2.
- AW, 3, address width; must equal log2(DEPTH).
- AF_LEVEL, 6, `almost_full` asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- write  input  1  push request; `data_write` captured when accepted.
- data_write  input  32  word to push.
- read  input  1  pop request from the read controller.
- data_read  output  32  registered output word, last popped entry.
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.
- almost_full  output  1  high when count >= AF_LEVEL.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- clr_err  input  1  clears `overflow` and `underflow`.

Behaviour:
- **Reset.** `rst` sampled high at a clock edge sets wr_ptr=0, rd_ptr=0, count=0, data_read=32'h0, overflow=0, underflow=0. The flags then read empty=1, full=0, almost_full=0 (AF_LEVEL>=1). Memory contents are not reset. A reset mid-operation discards all stored words, with no partial pop or push on that edge.
- **Flags.** `empty`, `full` and `almost_full` are decoded from the registered `count`, so they change the cycle after the edge that changes `count`.
- **Write acceptance.** Accepted when write=1 and (full=0 or read accepted same cycle). An accepted write stores `data_write` at mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- **Read acceptance.** Accepted when read=1 and empty=0. An accepted read loads mem[rd_ptr] into `data_read` on that edge, so the word is valid the cycle after `read` (1-cycle latency). rd_ptr increments modulo DEPTH. `data_read` holds its value when no read is accepted.
- **Simultaneous read and write:**
  - not empty, not full: both accepted, count unchanged.
  - full: both accepted; the read frees the slot the write fills; count stays DEPTH; no overflow.
  - empty: write accepted, read rejected; underflow sets; count becomes 1; data_read unchanged. There is no fall-through.
- **Count.** +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
- **Pointer wrap.** AW-bit pointers wrap naturally from DEPTH-1 to 0. Full/empty are decided from `count`, never from pointer equality.
- **Overflow.** Sets on any write=1 that is not accepted.
- **Underflow.** Sets on any read=1 that is not accepted.
- **Error-flag clear.** clr_err=1 clears both flags on that edge. If a new error event occurs in the same cycle as clr_err, the flag sets (set wins over clear).
- **Downstream contract.** A read controller that pulses `read` for one cycle per word while `empty`=0 never causes underflow. Back-to-back reads every cycle are legal and sustain 1 word/cycle.
- **Reset priority.** Reset overrides all other inputs, including write, read and clr_err in the same cycle.

Test Plan:
- **Reset state.** Assert rst 2 cycles with write=1 and read=1 -> empty=1, full=0, count=0, data_read=0, overflow=0, underflow=0; no word stored.
- **Fill and drain (DEPTH=8).** Push 32'hA000_0000..32'hA000_0007 one per cycle -> full=1 and count=8 after the 8th edge; almost_full=1 once count reaches 6. Pop 8 single-cycle reads -> data_read matches in order one cycle after each read; empty=1 after the last.
- **Overflow/underflow.** Write 32'hDEAD_BEEF while full -> overflow=1, word not stored, count stays 8. Drain, then read while empty -> underflow=1, data_read unchanged. Pulse clr_err -> both flags 0.
- **Simultaneous full.** When full with write=1 and read=1 carrying 32'h1234_5678 -> count stays 8, oldest word appears on data_read, overflow stays 0. 32'h1234_5678 pops as the 8th subsequent word.
- **Simultaneous empty.** When empty, write=1 with 32'h5555_AAAA and read=1 -> underflow=1, count=1. The next read returns 32'h5555_AAAA.
- **Wrap and mid-operation reset.** Run 20 mixed push/pop cycles crossing the pointer wrap; compare against a reference queue model. Then assert rst with 3 words stored -> count=0, empty=1. The next push/pop returns only the new data.
